// File: rtl/exe_div_seq.sv
// exe_div_seq: multi-cycle integer divide sequencer for the EXE stage.
// Runs one div.w / mod.w / div.wu / mod.wu request as a radix-2 restoring
// division over 32 cycles. It holds the 32-bit result until the pipeline
// takes it.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   flush              abort current/pending op, result discarded
//   div_valid/ready    request handshake (ready only in IDLE)
//   div_op[3:0]        one-hot {mod_wu, div_wu, mod_w, div_w}
//   div_src1/src2      dividend / divisor
//   div_tag[4:0]       destination register, returned on res_tag
//   res_valid/ready    result handshake
//   result[31:0]       quotient or remainder
//   res_tag[4:0]       captured div_tag
//   busy               state != IDLE
//
// Build option: define DIV_ZERO_FAST_EN to finish divide-by-zero at accept
// (result valid one cycle after accept) instead of iterating 32 cycles.
//
// state | meaning
// IDLE  | waiting for a request, div_ready high
// CALC  | one restoring iteration per cycle, cnt counts down 31..0
// DONE  | result held until res_ready

module exe_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [3:0]  div_op,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic [4:0]  div_tag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic [4:0]  res_tag,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        init_done;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [31:0] dividend_orig;
    logic [4:0]  cnt;
    logic        op_mod;
    logic        neg_quo;
    logic        neg_rem;
    logic        div_zero;

    logic        req_signed;
    logic        req_mod;
    logic        req_zero;
    logic [31:0] src1_abs;
    logic [31:0] src2_abs;

    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        rem_ge;
    logic [32:0] rem_new;
    logic [31:0] quo_new;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_val;

    // The running remainder is always below the divisor after an iteration,
    // so its top bit never feeds the next shift; only the compare needs 33 bits.
    logic        unused_bits;
    assign unused_bits = ^{rem[32], rem_new[32]};

    assign req_signed = div_op[0] | div_op[1];
    assign req_mod    = div_op[1] | div_op[3];
    assign req_zero   = (div_src2 == 32'd0);
    assign src1_abs   = (req_signed && div_src1[31]) ? -div_src1 : div_src1;
    assign src2_abs   = (req_signed && div_src2[31]) ? -div_src2 : div_src2;

    assign rem_shift = {rem[31:0], quo[31]};
    assign rem_sub   = rem_shift - {1'b0, divisor};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_new   = rem_ge ? rem_sub : rem_shift;
    assign quo_new   = {quo[30:0], rem_ge};

    assign quo_fix = neg_quo ? -quo_new : quo_new;
    assign rem_fix = neg_rem ? -rem_new[31:0] : rem_new[31:0];

    // Divide by zero bypasses the sign fix-up entirely.
    always_comb begin
        final_val = op_mod ? rem_fix : quo_fix;
        if (div_zero) begin
            final_val = op_mod ? dividend_orig : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            init_done     <= 1'b0;
            rem           <= '0;
            quo           <= '0;
            divisor       <= '0;
            dividend_orig <= '0;
            cnt           <= '0;
            op_mod        <= 1'b0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            result        <= '0;
            res_tag       <= '0;
        end else begin
            init_done <= 1'b1;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (div_valid && (div_op != 4'd0)) begin
                            rem           <= '0;
                            quo           <= src1_abs;
                            divisor       <= src2_abs;
                            dividend_orig <= div_src1;
                            cnt           <= 5'd31;
                            op_mod        <= req_mod;
                            neg_quo       <= req_signed & (div_src1[31] ^ div_src2[31]);
                            neg_rem       <= req_signed & div_src1[31];
                            div_zero      <= req_zero;
                            res_tag       <= div_tag;
`ifdef DIV_ZERO_FAST_EN
                            if (req_zero) begin
                                state  <= DONE;
                                result <= req_mod ? div_src1 : 32'hFFFF_FFFF;
                            end else begin
                                state <= CALC;
                            end
`else
                            state <= CALC;
`endif
                        end
                    end
                    CALC: begin
                        rem <= rem_new;
                        quo <= quo_new;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            state  <= DONE;
                            result <= final_val;
                        end
                    end
                    DONE: begin
                        if (res_ready) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign div_ready = (state == IDLE) && init_done;
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

endmodule

// File: tb/tb_exe_div_seq.sv
module tb_exe_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        div_valid;
    logic        div_ready;
    logic [3:0]  div_op;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic [4:0]  div_tag;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic [4:0]  res_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_DIV_W  = 4'b0001;
    localparam logic [3:0] OP_MOD_W  = 4'b0010;
    localparam logic [3:0] OP_DIV_WU = 4'b0100;
    localparam logic [3:0] OP_MOD_WU = 4'b1000;

    always #5 clk = ~clk;

    exe_div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_op    (div_op),
        .div_src1  (div_src1),
        .div_src2  (div_src2),
        .div_tag   (div_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: architectural divide semantics with plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == OP_DIV_W || op == OP_MOD_W) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == OP_MOD_W || op == OP_MOD_WU) ? r : q;
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input int hold);
        logic [31:0] exp;
        int lat;
        exp = ref_div(op, a, b);
        check("ready_before_accept", {31'd0, div_ready}, 32'd1);
        div_valid = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
        div_tag   = tg;
        tick();
        div_valid = 1'b0;
        div_src1  = $urandom;
        div_src2  = $urandom;
        div_tag   = 5'($urandom);
        check("busy_cycle1", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, ref_latency(b));
        check("result", result, exp);
        check("res_tag", {27'd0, res_tag}, {27'd0, tg});
        for (int i = 0; i < hold; i++) begin
            check("hold_ready_low", {31'd0, div_ready}, 32'd0);
            tick();
            check("hold_result", result, exp);
            check("hold_tag", {27'd0, res_tag}, {27'd0, tg});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("valid_after_take", {31'd0, res_valid}, 32'd0);
        check("ready_after_take", {31'd0, div_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0] ops [4];
        int seen;
        ops[0] = OP_DIV_W;
        ops[1] = OP_MOD_W;
        ops[2] = OP_DIV_WU;
        ops[3] = OP_MOD_WU;

        reset = 1'b1;
        flush = 1'b0;
        div_valid = 1'b0;
        div_op = 4'd0;
        div_src1 = '0;
        div_src2 = '0;
        div_tag = '0;
        res_ready = 1'b0;

        tick();
        tick();
        check("rst_ready", {31'd0, div_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag", {27'd0, res_tag}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, div_ready}, 32'd1);

        run_op(OP_DIV_WU, 32'd7, 32'd2, 5'd1, 0);
        run_op(OP_MOD_WU, 32'd7, 32'd2, 5'd2, 0);
        run_op(OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 5'd3, 1);
        run_op(OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        run_op(OP_MOD_W, 32'd7, 32'hFFFF_FFFE, 5'd6, 0);
        run_op(OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        run_op(OP_DIV_W, 32'h1234_5678, 32'd0, 5'd9, 0);
        run_op(OP_MOD_W, 32'h1234_5678, 32'd0, 5'd10, 0);
        run_op(OP_MOD_WU, 32'hF234_5678, 32'd0, 5'd11, 0);
        run_op(OP_DIV_WU, 32'hFFFF_FFFF, 32'd1, 5'd12, 5);
        run_op(OP_MOD_W, 32'h8000_0000, 32'd3, 5'd13, 0);

        // Flush in cycle 10 of a running divide.
        div_valid = 1'b1;
        div_op = OP_DIV_WU;
        div_src1 = 32'd1000;
        div_src2 = 32'd3;
        div_tag = 5'd5;
        tick();
        div_valid = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, div_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) seen++;
            tick();
        end
        check("flush_no_result", seen, 32'd0);

        // Flush together with a request in IDLE: not accepted.
        div_valid = 1'b1;
        flush = 1'b1;
        tick();
        div_valid = 1'b0;
        flush = 1'b0;
        check("flush_beats_valid", {31'd0, busy}, 32'd0);

        // div_op of zero is ignored.
        div_valid = 1'b1;
        div_op = 4'd0;
        tick();
        div_valid = 1'b0;
        check("zero_op_ignored", {31'd0, busy}, 32'd0);

        // Flush in DONE while res_ready is high: result dropped.
        div_valid = 1'b1;
        div_op = OP_DIV_WU;
        div_src1 = 32'd9;
        div_src2 = 32'd4;
        tick();
        div_valid = 1'b0;
        for (int c = 0; c < 40 && !res_valid; c++) tick();
        check("pre_flush_done", {31'd0, res_valid}, 32'd1);
        flush = 1'b1;
        res_ready = 1'b1;
        tick();
        flush = 1'b0;
        res_ready = 1'b0;
        check("flush_done_valid", {31'd0, res_valid}, 32'd0);
        check("flush_done_ready", {31'd0, div_ready}, 32'd1);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(ops[$urandom_range(0, 3)], a, b, 5'($urandom), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
